// File: rtl/cla_adder4_reg.sv
// Registered two-level carry-lookahead adder, every internal carry exposed.
// Define CLA_IN_REG_EN to also register A/B/Cin (latency becomes 2 clk).
module cla_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic [2:0] co,
  output logic       gp,
  output logic       gg
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // c4 is not produced here; the second level builds it from gg/gp
  always_comb begin
    c[0] = c0;
    c[1] = g[0]
         | (p[0] & c0);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c0);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    gp   = &p;
    gg   = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  end

  assign s  = p ^ c;
  assign co = c[3:1];
endmodule

module cla_adder4_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH:0]   C,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  localparam int NG = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_adder4_reg: WIDTH must be a positive multiple of 4");
  end

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

`ifdef CLA_IN_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= Cin;
    end
  end
`else
  assign a_q   = A;
  assign b_q   = B;
  assign cin_q = Cin;
`endif

  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      cg;
  logic             pr;
  logic [WIDTH:0]   c_d;
  logic [WIDTH-1:0] s_d;

  // Second level: each group carry is a flat sum of products over (gg,gp)
  always_comb begin
    cg = '0;
    pr = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      pr = cin_q;
      for (int m = 0; m < k; m++)
        pr = pr & gp[m];
      cg[k] = pr;
      for (int j = 0; j < k; j++) begin
        pr = gg[j];
        for (int m = j + 1; m < k; m++)
          pr = pr & gp[m];
        cg[k] = cg[k] | pr;
      end
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [2:0] co;
    cla_group u_grp (
      .a  (a_q[4*g +: 4]),
      .b  (b_q[4*g +: 4]),
      .c0 (cg[g]),
      .s  (s_d[4*g +: 4]),
      .co (co),
      .gp (gp[g]),
      .gg (gg[g])
    );
    assign c_d[4*g]       = cg[g];
    assign c_d[4*g+3 -: 3] = co;
  end
  assign c_d[WIDTH] = cg[NG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C <= '0;
      S <= '0;
    end else begin
      C <= c_d;
      S <= s_d;
    end
  end

  assign Cout = C[WIDTH];
endmodule

// File: tb/tb_cla_adder4_reg.sv
// Scoreboarded random/directed bench for cla_adder4_reg (WIDTH=4).
// Expected values come from plain integer addition.
module tb_cla_adder4_reg;
  localparam int W = 4;
`ifdef CLA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [W:0]   c;
    logic [W-1:0] s;
    logic         co;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic [W:0]   C;
  logic [W-1:0] S;
  logic         Cout;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cla_adder4_reg #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .C    (C),
    .S    (S),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b, input int ci);
    exp_t e;
    int   sum;
    int   m;
    sum   = a + b + ci;
    e.s   = W'(sum);
    e.co  = ((sum >> W) & 1) != 0;
    e.c[0] = ci[0];
    for (int i = 1; i <= W; i++) begin
      m = 1 << i;
      e.c[i] = ((((a % m) + (b % m) + ci) >> i) & 1) != 0;
    end
    e.a   = W'(a);
    e.b   = W'(b);
    e.cin = ci[0];
    e.due = 0;
    return e;
  endfunction

  task automatic issue(input int a, input int b, input int ci);
    exp_t e;
    @(negedge clk);
    A   = W'(a);
    B   = W'(b);
    Cin = ci[0];
    e = model(a, b, ci);
    e.due = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (C !== '0 || S !== '0 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL %s: got C=%b S=%b Cout=%b, need all zero",
               tag, C, S, Cout);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, need 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compare whatever result is due after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due == cyc) begin
          checks++;
          if (C !== e.c || S !== e.s || Cout !== e.co) begin
            errors++;
            $display("FAIL add %b+%b+%b: got C=%b S=%b Cout=%b, need C=%b S=%b Cout=%b",
                     e.a, e.b, e.cin, C, S, Cout, e.c, e.s, e.co);
          end
        end
      end
    end
  end

  initial begin
    #1;
    check_zero("reset_initial");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(4'b0000, 4'b0000, 0);
    issue(4'b1111, 4'b0100, 0);
    issue(4'b0010, 4'b1000, 0);
    issue(4'b0111, 4'b0110, 1);
    issue(4'b1110, 4'b0110, 0);
    drain();

    // Asynchronous reset between edges while outputs are nonzero
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_held");
    q.delete();
    rst = 1'b0;
    A   = 4'b1111;
    B   = 4'b0000;
    Cin = 1'b1;
    begin
      exp_t e;
      e = model(15, 0, 1);
      e.due = cyc + LAT;
      q.push_back(e);
    end
    drain();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++)
          issue(a, b, ci);
    drain();

    for (int i = 0; i < 300; i++)
      issue($urandom_range(15), $urandom_range(15), $urandom_range(1));
    issue(0, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
